// File: rtl/instr_mem_loader.sv
// Program loader: frames a byte stream (start, length, data, checksum)
// into little-endian words on the instruction-memory write port.
module instr_mem_loader #(
    parameter int          DWIDTH     = 32,
    parameter int          MEM_SIZE   = 16384,
    parameter logic [7:0]  START_BYTE = 8'hA5
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core,
    input  logic [7:0]        Rx_Data,
    input  logic              Rx_Valid,
    output logic              Rx_Ready,
    output logic              Mem_Wr_En,
    output logic [DWIDTH-1:0] Mem_Wr_Addr,
    output logic [31:0]       Mem_Wr_Data,
    output logic              Core_Hold,
    output logic              Load_Done,
    output logic              Load_Err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(MEM_SIZE);

    state_t            r_state;
    logic [15:0]       r_word_cnt;
    logic [15:0]       r_word_idx;
    logic [1:0]        r_byte_idx;
    logic [7:0]        r_csum;
    logic [23:0]       r_asm;
    logic              r_wr_en;
    logic [DWIDTH-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_done;
    logic              r_err;

    logic              w_fire;
    logic [15:0]       w_len;
    logic              w_last;
    logic [DWIDTH-1:0] w_word_addr;

    assign Rx_Ready    = !Rst_Core && (r_state != S_DONE);
    assign w_fire      = Rx_Valid && Rx_Ready;
    assign w_len       = {Rx_Data, r_word_cnt[7:0]};
    assign w_last      = (r_word_idx == r_word_cnt - 16'd1);
    assign w_word_addr = DWIDTH'({r_word_idx, 2'b00});

    assign Mem_Wr_En   = r_wr_en;
    assign Mem_Wr_Addr = r_wr_addr;
    assign Mem_Wr_Data = r_wr_data;
    assign Load_Done   = r_done;
    assign Load_Err    = r_err;
    assign Core_Hold   = (r_state != S_IDLE) || r_err;

    always_ff @(posedge Clk_Core) begin
        if (Rst_Core) begin
            r_state    <= S_IDLE;
            r_word_cnt <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_csum     <= '0;
            r_asm      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fire && Rx_Data == START_BYTE) begin
                        r_err      <= 1'b0;
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                        r_csum     <= '0;
                        r_state    <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_fire) begin
                        r_word_cnt[7:0] <= Rx_Data;
                        r_state         <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (w_fire) begin
                        r_word_cnt[15:8] <= Rx_Data;
                        if ({1'b0, w_len} > MAX_WORDS) begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end else if (w_len == 16'd0) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_fire) begin
                        r_csum     <= r_csum ^ Rx_Data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_asm[7:0]   <= Rx_Data;
                            2'd1: r_asm[15:8]  <= Rx_Data;
                            2'd2: r_asm[23:16] <= Rx_Data;
                            default: begin
                                // lane 3 completes the word; write it next cycle
                                r_wr_en    <= 1'b1;
                                r_wr_addr  <= w_word_addr;
                                r_wr_data  <= {Rx_Data, r_asm};
                                r_word_idx <= r_word_idx + 16'd1;
                                if (w_last)
                                    r_state <= S_CSUM;
                            end
                        endcase
                    end
                end
                S_CSUM: begin
                    if (w_fire) begin
                        if (Rx_Data == r_csum) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed vector bench for instr_mem_loader: each byte carries the
// expected outputs one cycle after it is accepted.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  Rx_Data;
    logic        Rx_Valid;
    logic        Rx_Ready;
    logic        Mem_Wr_En;
    logic [31:0] Mem_Wr_Addr;
    logic [31:0] Mem_Wr_Data;
    logic        Core_Hold;
    logic        Load_Done;
    logic        Load_Err;

    always #5 clk = ~clk;

    instr_mem_loader #(
        .DWIDTH(32),
        .MEM_SIZE(16),
        .START_BYTE(8'hA5)
    ) dut (
        .Clk_Core(clk),
        .Rst_Core(rst),
        .Rx_Data(Rx_Data),
        .Rx_Valid(Rx_Valid),
        .Rx_Ready(Rx_Ready),
        .Mem_Wr_En(Mem_Wr_En),
        .Mem_Wr_Addr(Mem_Wr_Addr),
        .Mem_Wr_Data(Mem_Wr_Data),
        .Core_Hold(Core_Hold),
        .Load_Done(Load_Done),
        .Load_Err(Load_Err)
    );

    typedef struct {
        logic [7:0]  d;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic        hold;
        logic        done;
        logic        err;
        logic        rdy;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_wr  = 0;

    // write monitor: counts strobes, sampled mid-cycle
    always @(negedge clk)
        if (!rst && Mem_Wr_En)
            n_wr++;

    task automatic add(input logic [7:0] d, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic hold, input logic done,
                       input logic err, input logic rdy);
        vec_t v;
        v.d = d; v.wr = wr; v.a = a; v.wd = wd;
        v.hold = hold; v.done = done; v.err = err; v.rdy = rdy;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Nominal two-word frame; last byte is the checksum under test.
    task automatic add_frame(input logic [7:0] cs, input logic good,
                             input logic err_before);
        add(8'hA5, 0, 0, 0, 1, 0, 0, 1);
        add(8'h02, 0, 0, 0, 1, 0, 0, 1);
        add(8'h00, 0, 0, 0, 1, 0, 0, 1);
        add(8'h13, 0, 0, 0, 1, 0, 0, 1);
        add(8'h05, 0, 0, 0, 1, 0, 0, 1);
        add(8'hC0, 0, 0, 0, 1, 0, 0, 1);
        add(8'h00, 1, 32'h0, 32'h00c00513, 1, 0, 0, 1);
        add(8'hEF, 0, 0, 0, 1, 0, 0, 1);
        add(8'h00, 0, 0, 0, 1, 0, 0, 1);
        add(8'h00, 0, 0, 0, 1, 0, 0, 1);
        add(8'h01, 1, 32'h4, 32'h010000ef, 1, 0, 0, 1);
        if (good) add(cs, 0, 0, 0, 1, 1, 0, 0);
        else      add(cs, 0, 0, 0, 1, 0, 1, 1);
        if (err_before) tbl[0].err = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int gap);
        int n;
        n = 0;
        repeat (gap) @(negedge clk);
        while (!Rx_Ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!Rx_Ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL ready_timeout: got 0 want 1");
        end
        Rx_Data  = v.d;
        Rx_Valid = 1'b1;
        @(negedge clk);
        Rx_Valid = 1'b0;
        n_vec++;
        if (Mem_Wr_En !== v.wr || Core_Hold !== v.hold ||
            Load_Done !== v.done || Load_Err !== v.err ||
            Rx_Ready !== v.rdy ||
            (v.wr && (Mem_Wr_Addr !== v.a || Mem_Wr_Data !== v.wd))) begin
            n_bad++;
            $display("FAIL vec byte=%h: got wr=%b a=%h d=%h hold=%b done=%b err=%b rdy=%b want wr=%b a=%h d=%h hold=%b done=%b err=%b rdy=%b",
                     v.d, Mem_Wr_En, Mem_Wr_Addr, Mem_Wr_Data, Core_Hold,
                     Load_Done, Load_Err, Rx_Ready, v.wr, v.a, v.wd,
                     v.hold, v.done, v.err, v.rdy);
        end
    endtask

    task automatic run(input int maxgap);
        foreach (tbl[i])
            apply(tbl[i], maxgap == 0 ? 0 : int'($urandom_range(0, maxgap)));
        tbl.delete();
    endtask

    initial begin
        int base;
        rst      = 1'b1;
        Rx_Data  = 8'h00;
        Rx_Valid = 1'b0;
        repeat (3) @(negedge clk);
        check("ready_in_reset", 32'(Rx_Ready), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_wr_en", 32'(Mem_Wr_En), 32'h0);
        check("rst_addr", Mem_Wr_Addr, 32'h0);
        check("rst_data", Mem_Wr_Data, 32'h0);
        check("rst_flags", {29'd0, Core_Hold, Load_Done, Load_Err}, 32'h0);
        check("rst_ready", 32'(Rx_Ready), 32'h1);

        // nominal load
        base = n_wr;
        add_frame(8'h38, 1, 0);
        run(0);
        @(negedge clk);
        check("hold_after_done", {30'd0, Core_Hold, Load_Done}, 32'h0);
        check("addr_holds", Mem_Wr_Addr, 32'h4);
        check("data_holds", Mem_Wr_Data, 32'h010000ef);
        check("nominal_writes", 32'(n_wr - base), 32'd2);

        // idle garbage
        base = n_wr;
        add(8'h00, 0, 0, 0, 0, 0, 0, 1);
        add(8'hFF, 0, 0, 0, 0, 0, 0, 1);
        add(8'h5A, 0, 0, 0, 0, 0, 0, 1);
        run(0);
        check("garbage_writes", 32'(n_wr - base), 32'd0);

        // bad checksum, then empty frame recovers
        base = n_wr;
        add_frame(8'h39, 0, 0);
        add(8'h5A, 0, 0, 0, 1, 0, 1, 1);
        add(8'hA5, 0, 0, 0, 1, 0, 0, 1);
        add(8'h00, 0, 0, 0, 1, 0, 0, 1);
        add(8'h00, 0, 0, 0, 1, 0, 0, 1);
        add(8'h00, 0, 0, 0, 1, 1, 0, 0);
        add(8'h00, 0, 0, 0, 0, 0, 0, 1);
        run(0);
        check("badcs_writes", 32'(n_wr - base), 32'd2);

        // oversize: N=17 with MEM_SIZE=16
        base = n_wr;
        add(8'hA5, 0, 0, 0, 1, 0, 0, 1);
        add(8'h11, 0, 0, 0, 1, 0, 0, 1);
        add(8'h00, 0, 0, 0, 1, 0, 1, 1);
        add(8'h33, 0, 0, 0, 1, 0, 1, 1);
        run(0);
        check("oversize_writes", 32'(n_wr - base), 32'd0);

        // N = MEM_SIZE exactly: 64 bytes 0..63, checksum 0
        base = n_wr;
        add(8'hA5, 0, 0, 0, 1, 0, 0, 1);
        add(8'h10, 0, 0, 0, 1, 0, 0, 1);
        add(8'h00, 0, 0, 0, 1, 0, 0, 1);
        for (int k = 0; k < 64; k++) begin
            logic [7:0] b;
            b = 8'(k);
            if (k % 4 == 3)
                add(b, 1, 32'(k - 3),
                    {b, b - 8'd1, b - 8'd2, b - 8'd3}, 1, 0, 0, 1);
            else
                add(b, 0, 0, 0, 1, 0, 0, 1);
        end
        add(8'h00, 0, 0, 0, 1, 1, 0, 0);
        run(0);
        check("full_writes", 32'(n_wr - base), 32'd16);

        // throttled nominal frame
        base = n_wr;
        add_frame(8'h38, 1, 0);
        run(5);
        check("throttle_writes", 32'(n_wr - base), 32'd2);

        // reset mid-DATA after 6 data bytes
        base = n_wr;
        add_frame(8'h38, 1, 0);
        tbl = tbl[0:8];
        run(0);
        rst = 1'b1;
        #1;
        check("ready_in_midreset", 32'(Rx_Ready), 32'h0);
        @(negedge clk);
        check("midreset_flags",
              {28'd0, Core_Hold, Load_Err, Mem_Wr_En, Rx_Ready}, 32'h0);
        rst = 1'b0;
        check("midreset_writes", 32'(n_wr - base), 32'd1);
        base = n_wr;
        add_frame(8'h38, 1, 0);
        run(0);
        check("reload_writes", 32'(n_wr - base), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
